ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 30 +++
 rtl/ram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the two-port RAM arbiter:
//   - FSM state encoding (IDLE, ACCESS, RESP)
//   - port index constants (PORT_A = CPU, PORT_B = I/O)
//   - round-robin winner selection helper
package ram_arbiter_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // A lone requester wins; on a tie the port that did not win last time wins.
    function automatic logic pick_winner(input logic req_a,
                                         input logic req_b,
                                         input logic last_grant);
        logic winner;
        if (req_a && req_b) begin
            winner = ~last_grant;
        end else if (req_a) begin
            winner = PORT_A;
        end else begin
            winner = PORT_B;
        end
        return winner;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Arbitrates a CPU port (a) and an I/O port (b) onto one single-ported RAM
// with asynchronous read data. Each access takes IDLE -> ACCESS -> RESP;
// a locked owner may chain RESP -> ACCESS for up to MAX_LOCK accesses.
// Ports:
//   clock, reset_n        : single clock, synchronous active-low reset
//   req/we/lock/addr/wdata_{a,b} : request inputs, held stable until ack
//   ack_{a,b}, rdata_{a,b}: one-cycle completion strobe and read data
//   gnt_{a,b}             : one-hot owner view, both 0 in IDLE
//   ram_*                 : RAM address/data/write-enable, ram_out read data
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_LOCK   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic                  lock_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic                  lock_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    localparam int              LW        = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [LW-1:0]   LOCK_LAST = LW'(MAX_LOCK - 1);

    logic [1:0]            state_r;
    logic [1:0]            state_nx_s;
    // last_grant_r doubles as the current owner while not in IDLE.
    logic                  last_grant_r;
    logic                  owner_nx_s;
    logic [LW-1:0]         lock_cnt_r;
    logic                  lock_clr_s;
    logic                  lock_inc_s;
    logic                  ack_a_r;
    logic                  ack_b_r;
    logic                  gnt_a_r;
    logic                  gnt_b_r;
    logic [DATA_WIDTH-1:0] rdata_a_r;
    logic [DATA_WIDTH-1:0] rdata_b_r;
    logic                  owner_req_s;
    logic                  owner_we_s;
    logic                  owner_lock_s;
    logic [ADDR_WIDTH-1:0] owner_addr_s;
    logic [DATA_WIDTH-1:0] owner_wdata_s;
    logic                  access_a_s;
    logic                  access_b_s;

    // Route the current owner's request inputs.
    always_comb begin
        if (last_grant_r == PORT_A) begin
            owner_req_s   = req_a;
            owner_we_s    = we_a;
            owner_lock_s  = lock_a;
            owner_addr_s  = addr_a;
            owner_wdata_s = wdata_a;
        end else begin
            owner_req_s   = req_b;
            owner_we_s    = we_b;
            owner_lock_s  = lock_b;
            owner_addr_s  = addr_b;
            owner_wdata_s = wdata_b;
        end
    end

    assign access_a_s = (state_r == ACCESS) && (last_grant_r == PORT_A);
    assign access_b_s = (state_r == ACCESS) && (last_grant_r == PORT_B);

    // Next-state, next-owner and lock counter control.
    always_comb begin
        state_nx_s = state_r;
        owner_nx_s = last_grant_r;
        lock_clr_s = 1'b0;
        lock_inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_a || req_b) begin
                    state_nx_s = ACCESS;
                    owner_nx_s = pick_winner(req_a, req_b, last_grant_r);
                    lock_clr_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCESS: begin
                // Never aborted, even if req drops here.
                state_nx_s = RESP;
            end
            RESP: begin
                if (owner_req_s && owner_lock_s && (lock_cnt_r < LOCK_LAST)) begin
                    state_nx_s = ACCESS;
                    lock_inc_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // RAM drive: only the owner in ACCESS touches the RAM; reset gates the write.
    always_comb begin
        if (state_r == ACCESS) begin
            ram_read_addr  = owner_addr_s;
            ram_write_addr = owner_addr_s;
            ram_data       = owner_wdata_s;
            ram_we         = owner_we_s & reset_n;
        end else begin
            ram_read_addr  = {ADDR_WIDTH{1'b0}};
            ram_write_addr = {ADDR_WIDTH{1'b0}};
            ram_data       = {DATA_WIDTH{1'b0}};
            ram_we         = 1'b0;
        end
    end

    // FSM state, owner and lock counter registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            last_grant_r <= PORT_B;
            lock_cnt_r   <= {LW{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            last_grant_r <= owner_nx_s;
            if (lock_clr_s) begin
                lock_cnt_r <= {LW{1'b0}};
            end else if (lock_inc_s) begin
                lock_cnt_r <= lock_cnt_r + LW'(1);
            end else begin
                lock_cnt_r <= lock_cnt_r;
            end
        end
    end

    // Registered ack and grant outputs; ack follows the ACCESS edge by one cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
        end else begin
            ack_a_r <= access_a_s;
            ack_b_r <= access_b_s;
            gnt_a_r <= (state_nx_s != IDLE) && (owner_nx_s == PORT_A);
            gnt_b_r <= (state_nx_s != IDLE) && (owner_nx_s == PORT_B);
        end
    end

    // Read data capture; ram_out is still the pre-write word at the ACCESS edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdata_a_r <= {DATA_WIDTH{1'b0}};
            rdata_b_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (access_a_s) begin
                rdata_a_r <= ram_out;
            end else begin
                rdata_a_r <= rdata_a_r;
            end
            if (access_b_s) begin
                rdata_b_r <= ram_out;
            end else begin
                rdata_b_r <= rdata_b_r;
            end
        end
    end

    assign ack_a   = ack_a_r;
    assign ack_b   = ack_b_r;
    assign gnt_a   = gnt_a_r;
    assign gnt_b   = gnt_b_r;
    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter: a RAM beside the arbiter, a
// schedule-based reference model compared every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_ram_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req_a, we_a, lock_a, req_b, we_b, lock_b;
    logic [13:0] addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        ack_a, ack_b, gnt_a, gnt_b, ram_we;
    logic [31:0] rdata_a, rdata_b, ram_data, ram_out;
    logic [13:0] ram_read_addr, ram_write_addr;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .MAX_LOCK(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a),
        .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b),
        .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .ram_data(ram_data), .ram_read_addr(ram_read_addr),
        .ram_write_addr(ram_write_addr), .ram_we(ram_we), .ram_out(ram_out)
    );

    // RAM beside the arbiter: async read, write on the rising clock edge.
    logic [31:0] ram_mem [0:16383];
    assign ram_out = ram_mem[ram_read_addr];
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_write_addr] <= ram_data;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-scheduled view: a tenure step is "access at cycle m_acc, response
    // at m_acc+1"; m_acc < 0 means nothing is scheduled.
    logic [31:0] mdl_mem [0:16383];
    int          cyc     = 0;
    int          m_acc   = -1;
    int          m_burst = 0;
    logic        m_owner = 1'b1;
    logic        m_last  = 1'b1;
    logic [31:0] m_rd_a  = 32'h0;
    logic [31:0] m_rd_b  = 32'h0;

    always @(negedge clock) begin : model
        logic        ow_we, ow_req, ow_lock, in_acc, in_resp;
        logic [13:0] ow_addr;
        logic [31:0] ow_wd;
        ow_we   = m_owner ? we_b    : we_a;
        ow_req  = m_owner ? req_b   : req_a;
        ow_lock = m_owner ? lock_b  : lock_a;
        ow_addr = m_owner ? addr_b  : addr_a;
        ow_wd   = m_owner ? wdata_b : wdata_a;
        in_acc  = (m_acc >= 0) && (cyc == m_acc);
        in_resp = (m_acc >= 0) && (cyc == m_acc + 1);
        if (chk_en) begin
            chk("m_ack_a", 32'(ack_a), 32'(in_resp && !m_owner));
            chk("m_ack_b", 32'(ack_b), 32'(in_resp && m_owner));
            chk("m_gnt_a", 32'(gnt_a), 32'((in_acc || in_resp) && !m_owner));
            chk("m_gnt_b", 32'(gnt_b), 32'((in_acc || in_resp) && m_owner));
            chk("m_rdata_a", rdata_a, m_rd_a);
            chk("m_rdata_b", rdata_b, m_rd_b);
            chk("m_ram_we", 32'(ram_we), 32'(in_acc && ow_we && reset_n));
            chk("m_ram_raddr", 32'(ram_read_addr), in_acc ? 32'(ow_addr) : 32'h0);
            chk("m_ram_waddr", 32'(ram_write_addr), in_acc ? 32'(ow_addr) : 32'h0);
            chk("m_ram_data", ram_data, in_acc ? ow_wd : 32'h0);
        end
        // Advance the model across the coming rising edge.
        if (!reset_n) begin
            m_acc = -1; m_burst = 0; m_last = 1'b1; m_owner = 1'b1;
            m_rd_a = 32'h0; m_rd_b = 32'h0;
        end else if (in_acc) begin
            if (m_owner) m_rd_b = mdl_mem[ow_addr];
            else         m_rd_a = mdl_mem[ow_addr];
            if (ow_we) mdl_mem[ow_addr] = ow_wd;
        end else if (in_resp) begin
            if (ow_req && ow_lock && m_burst < 8) begin
                m_acc = cyc + 1; m_burst++;
            end else begin
                m_acc = -1;
            end
        end else if (m_acc < 0 && (req_a || req_b)) begin
            if (req_a && req_b) m_owner = ~m_last;
            else                m_owner = req_b;
            m_last  = m_owner;
            m_acc   = cyc + 1;
            m_burst = 1;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        ram_mem[a] = v;
        mdl_mem[a] = v;
    endtask

    task automatic idle_inputs;
        req_a = 1'b0; we_a = 1'b0; lock_a = 1'b0; addr_a = 14'h0; wdata_a = 32'h0;
        req_b = 1'b0; we_b = 1'b0; lock_b = 1'b0; addr_b = 14'h0; wdata_b = 32'h0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        idle_inputs();
        tick();
        reset_n = 1'b1;
    endtask

    logic [31:0] ma, mb;
    int          na, nb;
    bit          pend_a, pend_b;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram_mem[i] = 32'h5A5A_0000 ^ i;
            mdl_mem[i] = 32'h5A5A_0000 ^ i;
        end
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("rst_ack_a", 32'(ack_a), 32'h0);
        chk("rst_ack_b", 32'(ack_b), 32'h0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_rdata_b", rdata_b, 32'h0);
        chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'h0);

        // Single read from reset.
        preload(32'h10, 32'hDEADBEEF);
        req_a = 1'b1; we_a = 1'b0; addr_a = 14'h10;
        tick();
        chk("rd_gnt_a_c1", 32'(gnt_a), 32'h1);
        chk("rd_ram_we_c1", 32'(ram_we), 32'h0);
        chk("rd_ack_a_c1", 32'(ack_a), 32'h0);
        tick();
        chk("rd_ack_a_c2", 32'(ack_a), 32'h1);
        chk("rd_rdata_a_c2", rdata_a, 32'hDEADBEEF);
        req_a = 1'b0;
        tick();
        chk("rd_ack_a_c3", 32'(ack_a), 32'h0);

        // Simultaneous writes from reset: a first, b second.
        do_reset();
        preload(1, 32'h0);
        preload(2, 32'h0);
        req_a = 1'b1; we_a = 1'b1; addr_a = 14'h1; wdata_a = 32'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 14'h2; wdata_b = 32'h22;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("sim_ack_a_c%0d", c), 32'(ack_a), 32'(c == 2));
            chk($sformatf("sim_ack_b_c%0d", c), 32'(ack_b), 32'(c == 5));
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
        end
        chk("sim_ram1", ram_mem[1], 32'h11);
        chk("sim_ram2", ram_mem[2], 32'h22);

        // Locked burst of 10 reads by a against a waiting b.
        do_reset();
        for (int i = 0; i < 10; i++) preload(32'h20 + i, 32'hA000_0000 + i);
        preload(32'h40, 32'hB0B0_B0B0);
        ma = 32'h0141_5554;   // a acks at 2,4,...,16,22,24
        mb = 32'h0008_0000;   // b ack at 19
        na = 0; nb = 0;
        req_a = 1'b1; lock_a = 1'b1; we_a = 1'b0; addr_a = 14'h20;
        req_b = 1'b1; we_b = 1'b0; addr_b = 14'h40;
        for (int c = 1; c <= 26; c++) begin
            tick();
            chk($sformatf("lk_ack_a_c%0d", c), 32'(ack_a), 32'(ma[c]));
            chk($sformatf("lk_ack_b_c%0d", c), 32'(ack_b), 32'(mb[c]));
            if (ack_a) begin
                chk("lk_rdata_a", rdata_a, 32'hA000_0000 + na);
                na++;
                if (na < 10) addr_a = 14'h20 + 14'(na);
                else begin req_a = 1'b0; lock_a = 1'b0; end
            end
            if (ack_b) begin
                chk("lk_rdata_b", rdata_b, 32'hB0B0_B0B0);
                req_b = 1'b0;
            end
        end
        chk("lk_count_a", 32'(na), 32'd10);

        // Reset in the middle of a write's ACCESS cycle.
        preload(3, 32'hA5A5_A5A5);
        req_a = 1'b1; we_a = 1'b1; addr_a = 14'h3; wdata_a = 32'h55;
        tick();
        chk("mr_gnt_a_c1", 32'(gnt_a), 32'h1);
        reset_n = 1'b0;
        req_a = 1'b0;
        #1;
        chk("mr_ram_we_c1", 32'(ram_we), 32'h0);
        tick();
        reset_n = 1'b1;
        chk("mr_ack", 32'({ack_a, ack_b}), 32'h0);
        chk("mr_gnt", 32'({gnt_a, gnt_b}), 32'h0);
        chk("mr_rdata_a", rdata_a, 32'h0);
        chk("mr_rdata_b", rdata_b, 32'h0);
        chk("mr_ram3", ram_mem[3], 32'hA5A5_A5A5);
        tick();
        chk("mr_ack_after", 32'({ack_a, ack_b}), 32'h0);

        // Alternating fairness with back-to-back unlocked writes.
        do_reset();
        ma = 32'h0010_4104;   // a acks at 2,8,14,20
        mb = 32'h0082_0820;   // b acks at 5,11,17,23
        na = 0; nb = 0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 14'h50; wdata_a = 32'hA0;
        req_b = 1'b1; we_b = 1'b1; addr_b = 14'h60; wdata_b = 32'hB0;
        for (int c = 1; c <= 26; c++) begin
            tick();
            chk($sformatf("alt_ack_a_c%0d", c), 32'(ack_a), 32'(ma[c]));
            chk($sformatf("alt_ack_b_c%0d", c), 32'(ack_b), 32'(mb[c]));
            if (ack_a) begin
                na++;
                if (na < 4) begin addr_a = 14'h50 + 14'(na); wdata_a = 32'hA0 + na; end
                else req_a = 1'b0;
            end
            if (ack_b) begin
                nb++;
                if (nb < 4) begin addr_b = 14'h60 + 14'(nb); wdata_b = 32'hB0 + nb; end
                else req_b = 1'b0;
            end
        end
        chk("alt_ram_a3", ram_mem[32'h53], 32'hA3);
        chk("alt_ram_b3", ram_mem[32'h63], 32'hB3);

        // Randomized traffic checked by the model alone.
        pend_a = 1'b0; pend_b = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            tick();
            if (!reset_n) reset_n = 1'b1;
            if (ack_a) pend_a = 1'b0;
            if (ack_b) pend_b = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                idle_inputs();
                pend_a = 1'b0; pend_b = 1'b0;
            end else begin
                if (!pend_a) begin
                    if ($urandom_range(0, 99) < 45) begin
                        req_a = 1'b1; we_a = 1'($urandom_range(0, 1));
                        lock_a = ($urandom_range(0, 99) < 40);
                        addr_a = 14'($urandom_range(0, 15)); wdata_a = $urandom;
                        pend_a = 1'b1;
                    end else begin
                        req_a = 1'b0; lock_a = 1'b0;
                    end
                end
                if (!pend_b) begin
                    if ($urandom_range(0, 99) < 45) begin
                        req_b = 1'b1; we_b = 1'($urandom_range(0, 1));
                        lock_b = ($urandom_range(0, 99) < 40);
                        addr_b = 14'($urandom_range(0, 15)); wdata_b = $urandom;
                        pend_b = 1'b1;
                    end else begin
                        req_b = 1'b0; lock_b = 1'b0;
                    end
                end
            end
        end
        idle_inputs();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
